// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - packs a stream of 8-bit pixels into 16-bit words for the frame memory
// First pixel of each pair goes to [7:0], second to [15:8]; words are written sequentially from base_addr.
module frame_writer #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int WORDS = IMG_W * IMG_H / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          mem_busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_data,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {IDLE, LO, HI, WR, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [7:0]    lo_q, lo_d;
  logic          abort_flag_q, abort_flag_d;
  logic          xfer;

  assign pix_ready  = (state_q == LO) || (state_q == HI);
  assign mem_we     = (state_q == WR) && !mem_busy;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign xfer       = pix_valid && pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      lo_q         <= '0;
      abort_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      lo_q         <= lo_d;
      abort_flag_q <= abort_flag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    data_d       = data_q;
    lo_d         = lo_q;
    abort_flag_d = abort_flag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d       = base_addr;
          idx_d        = '0;
          abort_flag_d = 1'b0;
          state_d      = LO;
        end
      end
      LO: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          lo_d    = pix_data;
          state_d = HI;
        end
      end
      HI: begin
        // An abort here still flushes the half-filled word, high byte zeroed.
        if (abort) begin
          data_d       = {8'h00, lo_q};
          addr_d       = base_q + idx_q;
          abort_flag_d = 1'b1;
          state_d      = WR;
        end else if (xfer) begin
          data_d  = {pix_data, lo_q};
          addr_d  = base_q + idx_q;
          state_d = WR;
        end
      end
      WR: begin
        if (mem_we) begin
          if (abort_flag_q || abort) begin
            abort_flag_d = 1'b0;
            state_d      = IDLE;
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = LO;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
